// File: rtl/musicrom_arbiter.sv
// rtl/musicrom_arbiter.sv - round-robin arbiter sharing the music ROM; MUSICROM_ARB_PRIO0_EN gives requester 0 fixed priority
module musicrom_arbiter #(
  parameter int NREQ      = 3,
  parameter int ROM_WIDTH = 17,
  parameter int RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*ROM_WIDTH-1:0] req_addr,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [7:0]                rsp_data,
  output logic [ROM_WIDTH-1:0]      rom_addr,
  input  logic [7:0]                rom_data
);

  localparam int              IW     = $clog2(NREQ);
  localparam logic [IW-1:0]   LAST   = IW'(NREQ - 1);
  localparam logic [IW:0]     NREQ_W = (IW + 1)'(NREQ);

  logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [ROM_WIDTH-1:0]       rom_addr_q, rom_addr_d;
  logic [RD_LAT:0]            tag_v_q, tag_v_d;
  logic [RD_LAT:0][IW-1:0]    tag_idx_q, tag_idx_d;
  logic [NREQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [7:0]                 rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]            scan_valid;
  logic [IW:0]                scan_idx;
  logic                       grant_any;
  logic [IW-1:0]              grant_idx;

  // Pick the winner: scan from rr_ptr upward with wrap; requester 0 may pre-empt when prioritised
  always_comb begin
    scan_valid = req_valid;
    grant_any  = 1'b0;
    grant_idx  = '0;
    scan_idx   = '0;
`ifdef MUSICROM_ARB_PRIO0_EN
    if (req_valid[0]) begin
      grant_any = 1'b1;
    end
    scan_valid[0] = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (IW + 1)'(k);
      if (scan_idx >= NREQ_W) begin
        scan_idx = scan_idx - NREQ_W;
      end
      if (!grant_any && scan_valid[scan_idx[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx[IW-1:0];
      end
    end
    if (reset) begin
      grant_any = 1'b0;
    end
  end

  // One-hot grant; a grant is an accept because it is only given to a valid requester
  always_comb begin
    req_ready = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Issue the accepted address, shift the tag pipeline and retire the oldest tag into a response
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    rom_addr_d   = rom_addr_q;
    tag_v_d      = '0;
    tag_idx_d    = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;

    tag_v_d[0]   = grant_any;
    tag_idx_d[0] = grant_idx;
    for (int s = 1; s <= RD_LAT; s++) begin
      tag_v_d[s]   = tag_v_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    if (grant_any) begin
      rom_addr_d = req_addr[grant_idx*ROM_WIDTH +: ROM_WIDTH];
`ifdef MUSICROM_ARB_PRIO0_EN
      if (grant_idx != '0) begin
        rr_ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
`else
      rr_ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
`endif
    end

    if (tag_v_q[RD_LAT]) begin
      rsp_valid_d[tag_idx_q[RD_LAT]] = 1'b1;
      rsp_data_d                     = rom_data;
    end
  end

  // State registers; reset drops every in-flight tag
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      rom_addr_q  <= '0;
      tag_v_q     <= '0;
      tag_idx_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rom_addr_q  <= rom_addr_d;
      tag_v_q     <= tag_v_d;
      tag_idx_q   <= tag_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_musicrom_arbiter.sv
// tb/tb_musicrom_arbiter.sv - self-checking bench for musicrom_arbiter at RD_LAT 1 and 3
module tb_musicrom_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 17;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ-1:0]      ready1, ready3, rsp_valid1, rsp_valid3;
  logic [7:0]           rsp_data1, rsp_data3, rom_data1, rom_data3;
  logic [AW-1:0]        rom_addr1, rom_addr3;
  logic [7:0]           rom3_p [0:2];

  always #5 clk = ~clk;

  musicrom_arbiter #(.NREQ(NREQ), .ROM_WIDTH(AW), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .rom_addr(rom_addr1), .rom_data(rom_data1));

  musicrom_arbiter #(.NREQ(NREQ), .ROM_WIDTH(AW), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
    .rom_addr(rom_addr3), .rom_data(rom_data3));

  // ROM contents: ROM[0x13] = 0x05, ROM[0x1FFFF] = 0x16
  function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
    return a[7:0] ^ a[16:9] ^ 8'h16;
  endfunction

  always @(posedge clk) rom_data1 <= rom_fn(rom_addr1);
  always @(posedge clk) begin
    rom3_p[0] <= rom_fn(rom_addr3);
    rom3_p[1] <= rom3_p[0];
    rom3_p[2] <= rom3_p[1];
  end
  assign rom_data3 = rom3_p[2];

  int n_checks = 0;
  int n_err    = 0;

  int           m_ptr;
  logic [AW-1:0] m_addr;
  int           cyc;
  bit           sv   [2][16];
  int           sidx [2][16];
  logic [7:0]   sd   [2][16];
  logic [7:0]   m_last [2];
  int           lat [2] = '{1, 3};
  int           last_grant;

  logic [NREQ-1:0] s_ready1, s_rsp_valid1, s_rsp_valid3;
  logic [7:0]      s_rsp_data1, s_rsp_data3;
  logic [AW-1:0]   s_rom_addr1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference arbitration: first valid requester at or after the pointer, wrapping
  function automatic int model_grant();
    int i;
    if (reset) return -1;
`ifdef MUSICROM_ARB_PRIO0_EN
    if (req_valid[0]) return 0;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (i != 0 && req_valid[i]) return i;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_clear();
    m_ptr  = 0;
    m_addr = '0;
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 8'h00;
      for (int s = 0; s < 16; s++) sv[d][s] = 1'b0;
    end
  endtask

  task automatic do_cycle();
    int g, s;
    logic [NREQ-1:0] er, ev;
    logic [7:0]      ed;
    @(negedge clk);
    s_ready1 = ready1; s_rom_addr1 = rom_addr1;
    s_rsp_valid1 = rsp_valid1; s_rsp_data1 = rsp_data1;
    s_rsp_valid3 = rsp_valid3; s_rsp_data3 = rsp_data3;
    g  = model_grant();
    er = (g >= 0) ? (NREQ'(1) << g) : '0;
    check("req_ready_lat1", ready1, er);
    check("req_ready_lat3", ready3, er);
    check("rom_addr_lat1", rom_addr1, m_addr);
    check("rom_addr_lat3", rom_addr3, m_addr);
    s = cyc % 16;
    for (int d = 0; d < 2; d++) begin
      ev = sv[d][s] ? (NREQ'(1) << sidx[d][s]) : '0;
      ed = sv[d][s] ? sd[d][s] : m_last[d];
      check(d == 0 ? "rsp_valid_lat1" : "rsp_valid_lat3", d == 0 ? rsp_valid1 : rsp_valid3, ev);
      check(d == 0 ? "rsp_data_lat1" : "rsp_data_lat3", d == 0 ? rsp_data1 : rsp_data3, ed);
      m_last[d] = ed;
      sv[d][s]  = 1'b0;
    end
    last_grant = g;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else if (g >= 0) begin
      m_addr = req_addr[g*AW +: AW];
      for (int d = 0; d < 2; d++) begin
        s = (cyc + lat[d] + 2) % 16;
        sv[d][s] = 1'b1; sidx[d][s] = g; sd[d][s] = rom_fn(m_addr);
      end
`ifdef MUSICROM_ARB_PRIO0_EN
      if (g != 0) m_ptr = (g + 1) % NREQ;
`else
      m_ptr = (g + 1) % NREQ;
`endif
    end
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; req_valid = '0;
    do_cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] exp_ready;
  } vec_t;

  initial begin
    vec_t vecs [10];
    logic [NREQ-1:0] gr [9];
    logic [NREQ-1:0] rv [9];
    logic [7:0]      rd [9];

    reset = 1'b1; req_valid = '0; req_addr = '0; cyc = 0;
    @(posedge clk); #1;
    model_clear();
    reset = 1'b0;

    // reset state and test 1: single read from requester 0
    do_cycle();
    req_valid = 3'b001; req_addr[0 +: AW] = 17'h00013;
    do_cycle();
    check("t1_grant", s_ready1, 3'b001);
    req_valid = '0;
    do_cycle();
    check("t1_rom_addr", s_rom_addr1, 17'h00013);
    do_cycle();
    do_cycle();
    check("t1_rsp_valid", s_rsp_valid1, 3'b001);
    check("t1_rsp_data", s_rsp_data1, 8'h05);
    do_cycle();
    do_cycle();
    check("t1_rsp_valid_lat3", s_rsp_valid3, 3'b001);
    check("t1_rsp_data_lat3", s_rsp_data3, 8'h05);

`ifndef MUSICROM_ARB_PRIO0_EN
    // test 2: all valid for six cycles from reset
    reset_dut();
    req_addr = {17'h30, 17'h20, 17'h10};
    for (int k = 0; k < 9; k++) begin
      req_valid = (k < 6) ? 3'b111 : 3'b000;
      do_cycle();
      gr[k] = s_ready1; rv[k] = s_rsp_valid1; rd[k] = s_rsp_data1;
    end
    for (int k = 0; k < 6; k++) begin
      check("t2_grant", gr[k], 3'b001 << (k % 3));
      check("t2_rsp_valid", rv[k+3], 3'b001 << (k % 3));
      check("t2_rsp_data", rd[k+3], rom_fn(17'h10 * ((k % 3) + 1)));
    end

    // table-driven arbitration sequence from reset
    vecs[0] = '{3'b111, 3'b001};
    vecs[1] = '{3'b111, 3'b010};
    vecs[2] = '{3'b111, 3'b100};
    vecs[3] = '{3'b110, 3'b010};
    vecs[4] = '{3'b000, 3'b000};
    vecs[5] = '{3'b001, 3'b001};
    vecs[6] = '{3'b101, 3'b100};
    vecs[7] = '{3'b100, 3'b100};
    vecs[8] = '{3'b011, 3'b001};
    vecs[9] = '{3'b011, 3'b010};
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      req_valid = vecs[k].valid;
      req_addr  = {AW'(k + 17'h200), AW'(k + 17'h100), AW'(k)};
      do_cycle();
      check("table_grant", s_ready1, vecs[k].exp_ready);
    end
    req_valid = '0;
`endif

    // test 3: only requester 2, four back-to-back reads
    reset_dut();
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 4) ? 3'b100 : 3'b000;
      req_addr[2*AW +: AW] = AW'(17'h100 + k);
      do_cycle();
      gr[k] = s_ready1; rv[k] = s_rsp_valid1; rd[k] = s_rsp_data1;
    end
    for (int k = 0; k < 4; k++) begin
      check("t3_grant", gr[k], 3'b100);
      check("t3_rsp_valid", rv[k+3], 3'b100);
      check("t3_rsp_data", rd[k+3], rom_fn(AW'(17'h100 + k)));
    end

    // test 4: reset one cycle after accepting requester 1
    reset_dut();
    req_valid = 3'b010; req_addr = {17'h66, 17'h55, 17'h44};
    do_cycle();
    check("t4_accept", s_ready1, 3'b010);
    reset = 1'b1; req_valid = 3'b110;
    do_cycle();
    check("t4_ready_in_reset", s_ready1, 3'b000);
    reset = 1'b0;
    do_cycle();
    check("t4_no_rsp", s_rsp_valid1, 3'b000);
    check("t4_rom_addr", s_rom_addr1, 17'h0);
    check("t4_regrant", s_ready1, 3'b010);
    req_valid = '0;
    for (int k = 0; k < 5; k++) do_cycle();

`ifdef MUSICROM_ARB_PRIO0_EN
    // test 5: requester 0 always wins, then 1 and 2 share
    reset_dut();
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      do_cycle();
      check("t5_prio0", s_ready1, 3'b001);
    end
    req_valid = 3'b110;
    do_cycle();
    check("t5_after_drop_1", s_ready1, 3'b010);
    do_cycle();
    check("t5_after_drop_2", s_ready1, 3'b100);
    req_valid = '0;
    for (int k = 0; k < 5; k++) do_cycle();
`endif

    // test 6: top address through the RD_LAT=3 instance
    reset_dut();
    req_valid = 3'b010; req_addr[AW +: AW] = 17'h1FFFF;
    for (int k = 0; k < 7; k++) begin
      do_cycle();
      req_valid = '0;
      rv[k] = s_rsp_valid3; rd[k] = s_rsp_data3;
    end
    check("t6_early", rv[4], 3'b000);
    check("t6_rsp_valid", rv[5], 3'b010);
    check("t6_rsp_data", rd[5], 8'h16);
    check("t6_one_shot", rv[6], 3'b000);

    // randomized traffic against the reference model
    last_grant = -1;
    for (int k = 0; k < 800; k++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_grant == i) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_addr[i*AW +: AW] = AW'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      do_cycle();
    end
    reset = 1'b0; req_valid = '0;
    for (int k = 0; k < 6; k++) do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
